// File: rtl/grad_prep_pkg.sv
// Shared constants and types for the gradient front end (grad_prep).
package grad_prep_pkg;

  localparam int unsigned BIN_W          = 5;
  localparam int unsigned NBINS_UNSIGNED = 9;
  localparam int unsigned NBINS_SIGNED   = 18;
  localparam int unsigned TAN_W          = 12;

  // Q8 tangents of 20/40/60/80 degrees; index 0 is tan 20.
  localparam logic [3:0][TAN_W-1:0] TAN_Q8 = {12'd1452, 12'd443, 12'd215, 12'd93};

  // Angular quadrant of the gradient; each maps the sector count n to a bin.
  typedef enum logic [1:0] {
    QUAD_I,
    QUAD_II,
    QUAD_III,
    QUAD_IV
  } quad_t;

  function automatic logic [BIN_W-1:0] bin_from_quad(input quad_t q, input logic [2:0] n);
    logic [BIN_W-1:0] b;
    case (q)
      QUAD_I:   b = BIN_W'(n);
      QUAD_II:  b = BIN_W'(NBINS_UNSIGNED - 1) - BIN_W'(n);
      QUAD_III: b = BIN_W'(NBINS_UNSIGNED) + BIN_W'(n);
      QUAD_IV:  b = BIN_W'(NBINS_SIGNED - 1) - BIN_W'(n);
      default:  b = BIN_W'(n);
    endcase
    return b;
  endfunction

endpackage

// File: rtl/grad_delay.sv
// Fixed-depth shift register with asynchronous active-low clear.
module grad_delay #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_sr [DEPTH];

  // Shift one stage per cycle; reset clears every entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < DEPTH; k++) r_sr[k] <= '0;
    end else begin
      r_sr[0] <= i_d;
      for (int unsigned k = 1; k < DEPTH; k++) r_sr[k] <= r_sr[k-1];
    end
  end

  assign o_q = r_sr[DEPTH-1];

endmodule

// File: rtl/grad_prep.sv
// Gradient front end: gx/gy, squared magnitude for the sqrt stage, and an
// orientation bin delayed to line up with the sqrt output.
// Build option GRAD_SIGNED_BIN_EN: 18 signed bins over 360 deg (default 9 unsigned).
module grad_prep
  import grad_prep_pkg::*;
#(
  parameter int unsigned PIX_W    = 8,
  parameter int unsigned MAG_W    = 18,
  parameter int unsigned SQRT_LAT = 13
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  input  logic [PIX_W-1:0] i_left,
  input  logic [PIX_W-1:0] i_right,
  input  logic [PIX_W-1:0] i_up,
  input  logic [PIX_W-1:0] i_down,
  output logic [MAG_W-1:0] o_mag_sq,
  output logic             o_sq_valid,
  output logic [BIN_W-1:0] o_bin_al,
  output logic             o_valid_al
);

  localparam int unsigned GW   = PIX_W + 1;
  localparam int unsigned SQ_W = 2 * PIX_W;
  localparam int unsigned CW   = PIX_W + TAN_W;

  // Stage 1
  logic signed [GW-1:0] r_s1_gx, r_s1_gy;
  // Stage 2
  logic [PIX_W-1:0] r_s2_ax, r_s2_ay;
  logic [SQ_W-1:0]  r_s2_sqx, r_s2_sqy;
  logic [3:0]       r_s2_c;
  logic             r_s2_zero;
  quad_t            r_s2_quad;
  // Stage 3
  logic [MAG_W-1:0] r_s3_mag;
  logic [BIN_W-1:0] r_s3_bin;

  logic             w_gx_neg, w_gy_neg, w_gx_zero, w_gy_zero, w_zero;
  logic [PIX_W-1:0] w_ax, w_ay;
  logic [3:0]       w_c;
  quad_t            w_quad;
  logic [2:0]       w_n;
  logic [BIN_W-1:0] w_bin;
  logic             w_sq_valid;
  logic [BIN_W:0]   w_al;

  // S1: central differences, signed PIX_W+1 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_gx <= '0;
      r_s1_gy <= '0;
    end else begin
      r_s1_gx <= $signed({1'b0, i_right}) - $signed({1'b0, i_left});
      r_s1_gy <= $signed({1'b0, i_down}) - $signed({1'b0, i_up});
    end
  end

  // S2 combinational: magnitudes, quadrant and tangent-threshold compares.
  always_comb begin
    w_gx_neg  = r_s1_gx[GW-1];
    w_gy_neg  = r_s1_gy[GW-1];
    w_gx_zero = (r_s1_gx == '0);
    w_gy_zero = (r_s1_gy == '0);
    w_zero    = w_gx_zero && w_gy_zero;
    w_ax      = w_gx_neg ? PIX_W'(-r_s1_gx) : r_s1_gx[PIX_W-1:0];
    w_ay      = w_gy_neg ? PIX_W'(-r_s1_gy) : r_s1_gy[PIX_W-1:0];
    w_quad    = QUAD_I;
`ifdef GRAD_SIGNED_BIN_EN
    if (!w_gx_neg && !w_gx_zero && !w_gy_neg)     w_quad = QUAD_I;
    else if ((w_gx_neg || w_gx_zero) && !w_gy_neg && !w_gy_zero) w_quad = QUAD_II;
    else if (w_gx_neg && (w_gy_neg || w_gy_zero)) w_quad = QUAD_III;
    else                                          w_quad = QUAD_IV;
`else
    // Folding (negating gx and gy when gx<0) leaves |gx|,|gy| unchanged and
    // only flips the sign of gy, so the fold reduces to this sign test.
    if (w_gx_neg ? (!w_gy_neg && !w_gy_zero) : w_gy_neg) w_quad = QUAD_II;
    else                                                 w_quad = QUAD_I;
`endif
    for (int unsigned k = 0; k < 4; k++)
      w_c[k] = (CW'(w_ay) << 8) >= (CW'(w_ax) * CW'(TAN_Q8[k]));
  end

  // S2 register: magnitudes, squares, compare flags, quadrant, zero flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_ax   <= '0;
      r_s2_ay   <= '0;
      r_s2_sqx  <= '0;
      r_s2_sqy  <= '0;
      r_s2_c    <= '0;
      r_s2_zero <= 1'b0;
      r_s2_quad <= QUAD_I;
    end else begin
      r_s2_ax   <= w_ax;
      r_s2_ay   <= w_ay;
      r_s2_sqx  <= SQ_W'(w_ax) * SQ_W'(w_ax);
      r_s2_sqy  <= SQ_W'(w_ay) * SQ_W'(w_ay);
      r_s2_c    <= w_c;
      r_s2_zero <= w_zero;
      r_s2_quad <= w_quad;
    end
  end

  // S3 combinational: sector count and final bin.
  always_comb begin
    w_n   = 3'(r_s2_c[0]) + 3'(r_s2_c[1]) + 3'(r_s2_c[2]) + 3'(r_s2_c[3]);
    w_bin = r_s2_zero ? '0 : bin_from_quad(r_s2_quad, w_n);
  end

  // S3 register: exact squared magnitude and bin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s3_mag <= '0;
      r_s3_bin <= '0;
    end else begin
      r_s3_mag <= MAG_W'(r_s2_sqx) + MAG_W'(r_s2_sqy);
      r_s3_bin <= w_bin;
    end
  end

  grad_delay #(
    .WIDTH(1),
    .DEPTH(3)
  ) u_valid_pipe (
    .clk  (clk),
    .rst_n(rst_n),
    .i_d  (i_valid),
    .o_q  (w_sq_valid)
  );

  grad_delay #(
    .WIDTH(BIN_W + 1),
    .DEPTH(SQRT_LAT)
  ) u_align (
    .clk  (clk),
    .rst_n(rst_n),
    .i_d  ({r_s3_bin, w_sq_valid}),
    .o_q  (w_al)
  );

  // The magnitude and ax/ay registers are kept for the sqrt hookup; ax/ay
  // themselves are only consumed through the squares.
  logic w_unused;
  assign w_unused = ^{r_s2_ax, r_s2_ay};

  assign o_mag_sq   = r_s3_mag;
  assign o_sq_valid = w_sq_valid;
  assign o_bin_al   = w_al[BIN_W:1];
  assign o_valid_al = w_al[0];

endmodule

// File: tb/tb_grad_prep.sv
module tb_grad_prep;

  localparam int unsigned PIX_W = 8;
  localparam int unsigned MAG_W = 18;
  localparam int unsigned LAT   = 13;
  localparam int          N     = 13;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             i_valid = 1'b0;
  logic [PIX_W-1:0] i_left = '0, i_right = '0, i_up = '0, i_down = '0;
  logic [MAG_W-1:0] o_mag_sq;
  logic             o_sq_valid;
  logic [4:0]       o_bin_al;
  logic             o_valid_al;

  grad_prep #(
    .PIX_W   (PIX_W),
    .MAG_W   (MAG_W),
    .SQRT_LAT(LAT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_valid   (i_valid),
    .i_left    (i_left),
    .i_right   (i_right),
    .i_up      (i_up),
    .i_down    (i_down),
    .o_mag_sq  (o_mag_sq),
    .o_sq_valid(o_sq_valid),
    .o_bin_al  (o_bin_al),
    .o_valid_al(o_valid_al)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [7:0]  l, r, u, d;
    logic [17:0] mag;
    logic [4:0]  bu, bs;
  } vec_t;

  vec_t tbl [N];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [4:0] exp_bin(input vec_t t);
`ifdef GRAD_SIGNED_BIN_EN
    return t.bs;
`else
    return t.bu;
`endif
  endfunction

  task automatic drive(input vec_t t);
    i_valid = t.v;
    i_left  = t.l;
    i_right = t.r;
    i_up    = t.u;
    i_down  = t.d;
  endtask

  initial begin
    vec_t idle;
    int   j, k;
    //            v     left     right    up       down     mag         unsigned signed
    tbl[0]  = '{1'b1, 8'd10,  8'd30,  8'd50,  8'd50,  18'd400,    5'd0, 5'd0};
    tbl[1]  = '{1'b1, 8'd30,  8'd10,  8'd50,  8'd50,  18'd400,    5'd0, 5'd9};
    tbl[2]  = '{1'b1, 8'd0,   8'd30,  8'd0,   8'd30,  18'd1800,   5'd2, 5'd2};
    tbl[3]  = '{1'b1, 8'd0,   8'd0,   8'd100, 8'd0,   18'd10000,  5'd4, 5'd13};
    tbl[4]  = '{1'b1, 8'd0,   8'd255, 8'd0,   8'd255, 18'd130050, 5'd2, 5'd2};
    tbl[5]  = '{1'b1, 8'd77,  8'd77,  8'd77,  8'd77,  18'd0,      5'd0, 5'd0};
    tbl[6]  = '{1'b0, 8'd200, 8'd3,   8'd9,   8'd1,   18'd0,      5'd0, 5'd0};
    tbl[7]  = '{1'b1, 8'd0,   8'd100, 8'd50,  8'd0,   18'd12500,  5'd7, 5'd16};
    tbl[8]  = '{1'b1, 8'd100, 8'd0,   8'd0,   8'd50,  18'd12500,  5'd7, 5'd7};
    tbl[9]  = '{1'b1, 8'd100, 8'd0,   8'd50,  8'd0,   18'd12500,  5'd1, 5'd10};
    tbl[10] = '{1'b1, 8'd0,   8'd0,   8'd0,   8'd100, 18'd10000,  5'd4, 5'd4};
    tbl[11] = '{1'b1, 8'd255, 8'd0,   8'd0,   8'd0,   18'd65025,  5'd0, 5'd9};
    tbl[12] = '{1'b1, 8'd0,   8'd10,  8'd0,   8'd40,  18'd1700,   5'd3, 5'd3};
    idle    = '{1'b0, 8'd0,   8'd0,   8'd0,   8'd0,   18'd0,      5'd0, 5'd0};

    // Power-on reset and reset-state outputs.
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_mag", 32'(o_mag_sq), 32'd0);
    chk("reset_sq_valid", 32'(o_sq_valid), 32'd0);
    chk("reset_bin", 32'(o_bin_al), 32'd0);
    chk("reset_valid_al", 32'(o_valid_al), 32'd0);
    rst_n = 1'b1;

    // Back-to-back stream with one gap; outputs checked at their latencies.
    for (int s = 0; s < N + 3 + int'(LAT) + 2; s++) begin
      j = s - 3;
      k = s - 3 - int'(LAT);
      if (j >= 0 && j < N) begin
        chk($sformatf("sq_valid[%0d]", j), 32'(o_sq_valid), 32'(tbl[j].v));
        if (tbl[j].v) chk($sformatf("mag[%0d]", j), 32'(o_mag_sq), 32'(tbl[j].mag));
      end else begin
        chk($sformatf("sq_valid_idle@%0d", s), 32'(o_sq_valid), 32'd0);
      end
      if (k >= 0 && k < N) begin
        chk($sformatf("valid_al[%0d]", k), 32'(o_valid_al), 32'(tbl[k].v));
        if (tbl[k].v) chk($sformatf("bin[%0d]", k), 32'(o_bin_al), 32'(exp_bin(tbl[k])));
      end else begin
        chk($sformatf("valid_al_idle@%0d", s), 32'(o_valid_al), 32'd0);
      end
      drive(s < N ? tbl[s] : idle);
      @(negedge clk);
    end

    // Mid-stream reset: valid pattern 1,1,0,1 then a one-cycle reset pulse.
    drive(tbl[2]);
    @(negedge clk);
    drive(tbl[2]);
    @(negedge clk);
    drive(idle);
    @(negedge clk);
    drive(tbl[2]);
    @(negedge clk);
    drive(idle);
    chk("pre_reset_sq_valid", 32'(o_sq_valid), 32'd1);
    chk("pre_reset_mag", 32'(o_mag_sq), 32'd1800);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_mag", 32'(o_mag_sq), 32'd0);
    chk("async_reset_sq_valid", 32'(o_sq_valid), 32'd0);
    chk("async_reset_bin", 32'(o_bin_al), 32'd0);
    chk("async_reset_valid_al", 32'(o_valid_al), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(tbl[7]);
    for (int c = 1; c <= 3 + int'(LAT) + 2; c++) begin
      @(negedge clk);
      drive(idle);
      chk($sformatf("post_reset_sq_valid@%0d", c), 32'(o_sq_valid), 32'(c == 3));
      chk($sformatf("post_reset_valid_al@%0d", c), 32'(o_valid_al), 32'(c == 3 + int'(LAT)));
      if (c == 3) chk("post_reset_mag", 32'(o_mag_sq), 32'(tbl[7].mag));
      if (c == 3 + int'(LAT)) chk("post_reset_bin", 32'(o_bin_al), 32'(exp_bin(tbl[7])));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
